// File: rtl/eth_64b66b_pkg.sv
// Shared 64b/66b definitions: sync header encoding, scrambler polynomial taps
// and the block-wide descramble function used by RTL and transmit-side models.
package eth_64b66b_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned HDR_W   = 2;
    localparam int unsigned SCR_LEN = 58;
    localparam int unsigned SCR_TAP = 39;

    typedef enum logic [HDR_W-1:0] {
        DATA = 2'b01,
        CTRL = 2'b10
    } sync_hdr_t;

    // Returns {descrambled payload, next scrambler state} for one 64-bit block.
    function automatic logic [DATA_W+SCR_LEN-1:0] descramble64(
        input logic [DATA_W-1:0]  d,
        input logic [SCR_LEN-1:0] scr
    );
        logic [DATA_W+SCR_LEN-1:0] x;
        logic [DATA_W-1:0]         o;
        x = {d, scr};
        for (int i = 0; i < DATA_W; i++) begin
            o[i] = d[i] ^ x[i+int'(SCR_LEN-SCR_TAP)] ^ x[i];
        end
        return {o, d[DATA_W-1:DATA_W-SCR_LEN]};
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (main + skid) with a registered upstream ready;
// strictly FIFO, full throughput when the downstream is ready.
module axis_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] main_data;
    logic         main_valid;
    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         ready_q;
    logic         accept;

    assign accept  = s_valid && ready_q;
    assign s_ready = ready_q;
    assign m_data  = main_data;
    assign m_valid = main_valid;

    // Main register refills from skid first; skid only captures while main is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (!main_valid || m_ready) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= s_data;
                end
            end
        end else if (accept) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
        end
    end

endmodule

// File: rtl/descrambler_64b66b.sv
// Self-synchronizing 1 + x^39 + x^58 descrambler for the 64b/66b receive path.
// Optional block/error statistics counters are enabled by DESCRAMBLER_STATS_EN.
module descrambler_64b66b
    import eth_64b66b_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HDR_W-1:0]  s_axis_ttype,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [HDR_W-1:0]  m_axis_ttype,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_terr
`ifdef DESCRAMBLER_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_blk_cnt,
    output logic [CNT_W-1:0]  stat_err_cnt
`endif
);

    localparam int unsigned PAY_W = 1 + HDR_W + DATA_W;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [SCR_LEN-1:0]        scr;
    logic [DATA_W+SCR_LEN-1:0] dsc;
    logic                      hdr_err;
    logic                      accept;
    logic [PAY_W-1:0]          pay_in;
    logic [PAY_W-1:0]          pay_out;

    assign dsc     = descramble64(s_axis_tdata, scr);
    assign hdr_err = !((s_axis_ttype == DATA) || (s_axis_ttype == CTRL));
    assign accept  = s_axis_tvalid && s_axis_tready;
    assign pay_in  = {hdr_err, s_axis_ttype, dsc[DATA_W+SCR_LEN-1:SCR_LEN]};

    // Scrambler history advances on every accepted beat regardless of header.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scr <= '0;
        end else if (accept) begin
            scr <= dsc[SCR_LEN-1:0];
        end
    end

    axis_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .s_data  (pay_in),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (pay_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_terr  = pay_out[PAY_W-1];
    assign m_axis_ttype = pay_out[DATA_W +: HDR_W];
    assign m_axis_tdata = pay_out[DATA_W-1:0];

`ifdef DESCRAMBLER_STATS_EN
    // Saturating counters; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_blk_cnt <= '0;
            stat_err_cnt <= '0;
        end else if (stat_clr) begin
            stat_blk_cnt <= '0;
            stat_err_cnt <= '0;
        end else if (accept) begin
            if (stat_blk_cnt != '1) begin
                stat_blk_cnt <= stat_blk_cnt + CNT_W'(1);
            end
            if (hdr_err && (stat_err_cnt != '1)) begin
                stat_err_cnt <= stat_err_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/descrambler_64b66b.md
# descrambler_64b66b

Self-synchronizing descrambler for the 64b/66b receive path. Sits directly downstream of `synchronizer` and consumes its block-aligned stream: 2-bit sync header on `ttype`, 64-bit scrambled payload on `tdata`. It removes the 1 + x^39 + x^58 scrambling from the payload, passes the header through unchanged, and flags invalid headers. Output goes to the 64b/66b block decoder.

## Interface
Parameters:
- `CNT_W`, 32: width of the statistics counters. Used only when `DESCRAMBLER_STATS_EN` is defined.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `s_axis_ttype`  in  2  sync header from `synchronizer`:
  - 2'b01 = data.
  - 2'b10 = control.
  - 2'b00 and 2'b11 are illegal.
- `s_axis_tdata`  in  64  scrambled payload; bit 0 is first on the wire.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input ready. Driven from a register.
- `m_axis_ttype`  out  2  header, passed through unchanged.
- `m_axis_tdata`  out  64  descrambled payload.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_terr`  out  1  sideband qualified by `m_axis_tvalid`; 1 when the beat's header is 2'b00 or 2'b11.
- `stat_clr`  in  1  synchronous clear of the counters. Present only with the macro.
- `stat_blk_cnt`  out  CNT_W  count of accepted blocks. Present only with the macro.
- `stat_err_cnt`  out  CNT_W  count of accepted blocks with an illegal header. Present only with the macro.

## Operation
- Input acceptance: a beat is accepted when `s_axis_tvalid && s_axis_tready`.
- Scrambler state `scr[57:0]` holds the last 58 received scrambled bits; `scr[57]` is the most recent.
- Per accepted beat, let x[121:0] = {d[63:0], scr[57:0]}:
  - out[i] = d[i] ^ x[i+19] ^ x[i], for i = 0..63.
  - scr_next = d[63:6].
- `scr` updates only on accepted beats. It is never altered by header value or by errors; the descrambler self-synchronizes 58 bits after any corruption.
- Illegal header: the payload is still descrambled, the header is passed through, and `terr` = 1.
- Output stage: a main register plus a one-entry skid register.
  - `s_axis_tready` = skid register empty.
  - When the main register is full and stalled (`m_axis_tvalid && !m_axis_tready`) and a beat is accepted, the beat goes into the skid register.
  - When the main register drains, the skid entry moves into it.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset values:
  - `scr` = 0.
  - Main and skid registers empty.
  - `m_axis_tvalid` = 0, `m_axis_ttype` = 0, `m_axis_tdata` = 0, `m_axis_terr` = 0.
  - `s_axis_tready` = 1.
  - Counters = 0.
- Latency: 1 cycle from acceptance to `m_axis_tvalid`.
- Throughput: 1 beat/cycle while `m_axis_tready` = 1.
- Stall: when the skid register fills, `s_axis_tready` drops on the next cycle. It returns to 1 the cycle after the skid register drains.
- Output stability: `m_axis_*` hold steady while `m_axis_tvalid && !m_axis_tready`.
- Simultaneous accept and drain with the skid register empty: the new beat goes straight into the main register, and the skid register stays empty.
- Reset mid-stream: all in-flight beats are discarded immediately (asynchronous) and `scr` returns to 0. The first 58 bits after reset may descramble wrongly; this is acceptable and flagged nowhere.

## Configuration
- `DESCRAMBLER_STATS_EN` defined:
  - Ports `stat_clr`, `stat_blk_cnt` and `stat_err_cnt` exist.
  - Counters increment on accepted beats and saturate at all-ones.
  - `stat_clr` takes priority over increment.
- `DESCRAMBLER_STATS_EN` undefined: those ports and the counter logic are absent. Datapath behaviour is identical.

## Structure
- Shared package `eth_64b66b_pkg` holds:
  - A `sync_hdr_t` enum: DATA = 2'b01, CTRL = 2'b10.
  - Constants SCR_LEN = 58 and SCR_TAP = 39.
  - A function `descramble64(d, scr)` returning {out, scr_next}, shared with the transmit-side scrambler model.
- One natural sub-module: `axis_skid_buffer`, a generic payload-width-parameterized skid stage that carries {terr, ttype, tdata}.

## Test plan
- Reset state, then drive ttype=01, tdata=64'h1 -> tdata = 64'h0400_0080_0000_0001 one cycle later; scr becomes 0.
- Directly after that, tdata=0 -> output 0. With scr seeded by a prior input tdata=64'hFFFF_FFFF_FFFF_FFFF, tdata=0 gives nonzero output matching the `descramble64` model.
- Scrambler-loopback: 1000 random blocks scrambled by the reference model -> outputs bit-exact after the first block; `terr` = 0 throughout.
- Headers 00 and 11 injected -> `m_axis_terr` = 1 on exactly those beats, ttype passed through, later blocks still correct. With the macro, `stat_err_cnt` = 2 and `stat_blk_cnt` = total beats.
- Random `m_axis_tready` backpressure at 30% duty -> no loss or reorder; `s_axis_tready` low only while the skid register is full; outputs stable during stalls.
- Reset asserted mid-burst with the skid register full -> `m_axis_tvalid` = 0 and `s_axis_tready` = 1 immediately; counters = 0.
